obstacle_lane_engine: RTL and testbench

//  Parametrised obstacle/game-state engine for the VGA dino game. Tracks NUM_OBS scrolling obstacles,

---
 rtl/obstacle_lane_engine_pkg.sv | 20 ++
 rtl/obstacle_lane_engine_lfsr16.sv | 37 +++
 rtl/obstacle_lane_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_obstacle_lane_engine.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_lane_engine_pkg.sv
// Shared types and helpers for the dino-game obstacle lane engine.
// Holds the game-state encoding, video geometry and the LFSR step function.
package obstacle_lane_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    localparam int unsigned VIDEO_WIDTH    = 640;
    localparam int unsigned VIDEO_HEIGHT   = 480;
    localparam int unsigned GROUND_DEFAULT = 335;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11, shifting towards the MSB.
    function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/obstacle_lane_engine_lfsr16.sv
// 16-bit maximal-length LFSR that steps once per enable pulse.
// Only the low OUT_W bits are exported; they set the random part of the spawn gap.
module lfsr16
    import obstacle_lane_engine_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned OUT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [OUT_W-1:0] state_lo
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = lfsr16_step(state_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_lo = state_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_lane_engine.sv
// Obstacle/game-state engine for the VGA dino game: scrolling obstacle slots, spawning,
// speed/score progression, IDLE/RUN/OVER FSM and pixel-exact collision against the dino sprite.
module obstacle_lane_engine
    import obstacle_lane_engine_pkg::*;
#(
    parameter int unsigned NUM_OBS    = 3,
    parameter int unsigned OBS_W      = 49,
    parameter int unsigned OBS_H      = 80,
    parameter int unsigned GROUND     = GROUND_DEFAULT,
    parameter int unsigned SPAWN_X    = 560,
    parameter int unsigned MIN_GAP    = 40,
    parameter int unsigned SPEED_INIT = 1,
    parameter int unsigned SPEED_MAX  = 6,
    parameter int unsigned SPEED_STEP = 600,
    parameter int unsigned SCORE_DIV  = 6,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [9:0]         x,
    input  logic [8:0]         y,
    input  logic               pix_valid,
    output logic [12:0]        obs_addr,
    input  logic               obs_sprite_bit,
    input  logic               dino_opaque,
    output logic               obs_pix,
    output logic [1:0]         game_state,
    output logic               game_over,
    output logic [15:0]        score,
    output logic [2:0]         speed,
    output logic [NUM_OBS-1:0] obs_active
);

    localparam logic [10:0] OBS_TOP  = 11'(GROUND - OBS_H);
    localparam logic [10:0] GROUND_Y = 11'(GROUND);
    localparam logic [10:0] OBS_W11  = 11'(OBS_W);
    localparam int unsigned GAP_W    = $clog2(MIN_GAP + 64);
    localparam int unsigned SDIV_W   = $clog2(SCORE_DIV + 1);
    localparam int unsigned SSTEP_W  = $clog2(SPEED_STEP + 1);

    game_state_e        state_q, state_d;
    logic               coll_q, coll_d, coll_hit;
    logic               start_q;
    logic               box_q, pix_valid_q;
    logic [GAP_W-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic [15:0]        score_q, score_d;
    logic [2:0]         speed_q, speed_d;
    logic [SDIV_W-1:0]  sdiv_q, sdiv_d;
    logic [SSTEP_W-1:0] sstep_q, sstep_d;

    logic               clear_run, frame_run;
    logic               spawn_due, spawn_go;
    logic [NUM_OBS-1:0] spawn_sel;
    logic               spawn_found;
    logic [NUM_OBS-1:0] active_q;
    logic [9:0]         obs_x [NUM_OBS];
    logic [5:0]         lfsr_lo;

    logic [10:0]        x11, y11, win_x;
    logic               hit_any, y_in_band;

    lfsr16 #(.SEED(LFSR_SEED), .OUT_W(6)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (frame_tick),
        .state_lo (lfsr_lo)
    );

    // A collision on the same clock as frame_tick suppresses that frame's update.
    assign coll_hit  = (state_q == ST_RUN) && pix_valid_q && obs_pix && dino_opaque;
    assign frame_run = frame_tick && (state_q == ST_RUN) && !coll_hit;

    always_comb begin
        state_d   = state_q;
        clear_run = 1'b0;
        coll_d    = coll_q | coll_hit;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_RUN;
                clear_run = 1'b1;
                coll_d    = 1'b0;
            end
            ST_RUN:  if (coll_d) state_d = ST_OVER;
            ST_OVER: if (start && !start_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lowest-index free slot, judged on occupancy before this frame's motion.
    always_comb begin
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!active_q[i] && !spawn_found) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    assign spawn_due = (spawn_cnt_q <= GAP_W'(1));
    assign spawn_go  = frame_run && spawn_due && spawn_found;

    always_comb begin
        spawn_cnt_d = spawn_cnt_q;
        score_d     = score_q;
        speed_d     = speed_q;
        sdiv_d      = sdiv_q;
        sstep_d     = sstep_q;
        if (clear_run) begin
            spawn_cnt_d = GAP_W'(MIN_GAP);
            score_d     = '0;
            speed_d     = 3'(SPEED_INIT);
            sdiv_d      = '0;
            sstep_d     = '0;
        end else if (frame_run) begin
            if (!spawn_due)       spawn_cnt_d = spawn_cnt_q - GAP_W'(1);
            else if (spawn_found) spawn_cnt_d = GAP_W'(MIN_GAP) + GAP_W'(lfsr_lo);
            else                  spawn_cnt_d = '0;

            if (sdiv_q == SDIV_W'(SCORE_DIV - 1)) begin
                sdiv_d = '0;
                if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            end else begin
                sdiv_d = sdiv_q + SDIV_W'(1);
            end

            if (sstep_q == SSTEP_W'(SPEED_STEP - 1)) begin
                sstep_d = '0;
                if (speed_q < 3'(SPEED_MAX)) speed_d = speed_q + 3'd1;
            end else begin
                sstep_d = sstep_q + SSTEP_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
        logic       act_q, act_d;
        logic [9:0] x_q, x_d;

        // Leaving the screen when x < speed retires the slot instead of wrapping x.
        always_comb begin
            act_d = act_q;
            x_d   = x_q;
            if (clear_run) begin
                act_d = 1'b0;
                x_d   = '0;
            end else if (frame_run) begin
                if (act_q) begin
                    if (x_q < 10'(speed_q)) act_d = 1'b0;
                    else                    x_d   = x_q - 10'(speed_q);
                end else if (spawn_go && spawn_sel[i]) begin
                    act_d = 1'b1;
                    x_d   = 10'(SPAWN_X);
                end
            end
        end

        // NOTE: slot registers are a handful of flops, not a RAM, so they take the async reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                act_q <= 1'b0;
                x_q   <= '0;
            end else begin
                act_q <= act_d;
                x_q   <= x_d;
            end
        end

        assign active_q[i] = act_q;
        assign obs_x[i]    = x_q;
    end

    assign x11       = {1'b0, x};
    assign y11       = {2'b0, y};
    assign y_in_band = (y11 >= OBS_TOP) && (y11 < GROUND_Y);

    always_comb begin
        hit_any = 1'b0;
        win_x   = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!hit_any && active_q[i] && y_in_band &&
                x11 >= {1'b0, obs_x[i]} && x11 < ({1'b0, obs_x[i]} + OBS_W11)) begin
                hit_any = 1'b1;
                win_x   = {1'b0, obs_x[i]};
            end
        end
    end

    assign obs_addr = hit_any ? (13'(y11 - OBS_TOP) * 13'(OBS_W) + 13'(x11 - win_x)) : 13'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            coll_q      <= 1'b0;
            start_q     <= 1'b0;
            box_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            spawn_cnt_q <= GAP_W'(MIN_GAP);
            score_q     <= '0;
            speed_q     <= 3'(SPEED_INIT);
            sdiv_q      <= '0;
            sstep_q     <= '0;
        end else begin
            state_q     <= state_d;
            coll_q      <= coll_d;
            start_q     <= start;
            box_q       <= hit_any;
            pix_valid_q <= pix_valid;
            spawn_cnt_q <= spawn_cnt_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            sdiv_q      <= sdiv_d;
            sstep_q     <= sstep_d;
        end
    end

    // Box flag is delayed one clk to line up with the sprite ROM read data.
    assign obs_pix    = box_q & obs_sprite_bit;
    assign game_state = state_q;
    assign game_over  = (state_q == ST_OVER);
    assign score      = score_q;
    assign speed      = speed_q;
    assign obs_active = active_q;

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// Directed bench for obstacle_lane_engine: reset, first spawn, long run with a slot model,
// collision/game-over, restart handshake and asynchronous mid-run reset.
module tb_obstacle_lane_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        pix_valid = 1'b0;
    logic        obs_sprite_bit = 1'b0;
    logic        dino_opaque = 1'b0;
    logic [12:0] obs_addr;
    logic        obs_pix;
    logic [1:0]  game_state;
    logic        game_over;
    logic [15:0] score;
    logic [2:0]  speed;
    logic [2:0]  obs_active;

    int total = 0;
    int bad   = 0;

    // Reference model of the lane, kept in spec terms.
    bit          m_act [3];
    int          m_x [3];
    int          m_spawn;
    int          m_run_frames;
    logic [15:0] m_lfsr = 16'hACE1;

    obstacle_lane_engine dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .start          (start),
        .x              (x),
        .y              (y),
        .pix_valid      (pix_valid),
        .obs_addr       (obs_addr),
        .obs_sprite_bit (obs_sprite_bit),
        .dino_opaque    (dino_opaque),
        .obs_pix        (obs_pix),
        .game_state     (game_state),
        .game_over      (game_over),
        .score          (score),
        .speed          (speed),
        .obs_active     (obs_active)
    );

    always #5 clk = ~clk;

    function automatic int model_speed();
        int s;
        s = 1 + m_run_frames / 600;
        return (s > 6) ? 6 : s;
    endfunction

    function automatic int model_score();
        int s;
        s = m_run_frames / 6;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic logic [2:0] model_active();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic int model_addr(input int px, input int py);
        for (int i = 0; i < 3; i++) begin
            if (m_act[i] && px >= m_x[i] && px < m_x[i] + 49 && py >= 255 && py < 335)
                return (py - 255) * 49 + (px - m_x[i]);
        end
        return 0;
    endfunction

    function automatic void model_clear_run();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
        end
        m_spawn      = 40;
        m_run_frames = 0;
    endfunction

    function automatic void model_tick(input bit run);
        int  spd;
        int  free_idx;
        bit  pre [3];
        if (run) begin
            spd      = model_speed();
            free_idx = -1;
            for (int i = 0; i < 3; i++) pre[i] = m_act[i];
            for (int i = 0; i < 3; i++) if (!pre[i] && free_idx < 0) free_idx = i;
            if (m_spawn > 0) m_spawn--;
            for (int i = 0; i < 3; i++) begin
                if (pre[i]) begin
                    if (m_x[i] < spd) m_act[i] = 1'b0;
                    else              m_x[i]   = m_x[i] - spd;
                end
            end
            if (m_spawn == 0 && free_idx >= 0) begin
                m_act[free_idx] = 1'b1;
                m_x[free_idx]   = 560;
                m_spawn         = 40 + int'(m_lfsr[5:0]);
            end
            m_run_frames++;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endfunction

    task automatic do_frame(input bit run);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick(run);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x = 10'd300;
        y = 9'd300;
        repeat (3) @(negedge clk);
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", game_state); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
        total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
        total++; if (speed !== 3'd1) begin bad++; $display("FAIL reset_speed got=%0d exp=1", speed); end
        total++; if (obs_active !== 3'b000) begin bad++; $display("FAIL reset_active got=%b exp=000", obs_active); end
        total++; if (obs_pix !== 1'b0) begin bad++; $display("FAIL reset_obs_pix got=%b exp=0", obs_pix); end
        total++; if (obs_addr !== 13'd0) begin bad++; $display("FAIL reset_obs_addr got=%0d exp=0", obs_addr); end
        reset = 1'b0;
        do_frame(1'b0);
        do_frame(1'b0);
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL idle_frames_state got=%0d exp=0", game_state); end
        total++; if (score !== 16'd0) begin bad++; $display("FAIL idle_frames_score got=%0d exp=0", score); end
    endtask

    task automatic test_first_spawn();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear_run();
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", game_state); end
        total++; if (speed !== 3'd1) begin bad++; $display("FAIL start_speed got=%0d exp=1", speed); end
        for (int f = 1; f <= 39; f++) do_frame(1'b1);
        total++; if (obs_active !== 3'b000) begin bad++; $display("FAIL no_spawn_before_40 got=%b exp=000", obs_active); end
        do_frame(1'b1);
        total++; if (obs_active !== 3'b001) begin bad++; $display("FAIL spawn_at_40 got=%b exp=001", obs_active); end
        x = 10'd561; y = 9'd256; #1;
        total++; if (obs_addr !== 13'd50) begin bad++; $display("FAIL addr_561_256 got=%0d exp=50", obs_addr); end
        x = 10'd608; y = 9'd334; #1;
        total++; if (obs_addr !== 13'd3919) begin bad++; $display("FAIL addr_last_px got=%0d exp=3919", obs_addr); end
        x = 10'd559; y = 9'd256; #1;
        total++; if (obs_addr !== 13'd0) begin bad++; $display("FAIL addr_left_edge got=%0d exp=0", obs_addr); end
        x = 10'd609; y = 9'd256; #1;
        total++; if (obs_addr !== 13'd0) begin bad++; $display("FAIL addr_right_edge got=%0d exp=0", obs_addr); end
        x = 10'd561; y = 9'd335; #1;
        total++; if (obs_addr !== 13'd0) begin bad++; $display("FAIL addr_ground got=%0d exp=0", obs_addr); end
        x = 10'd561; y = 9'd254; #1;
        total++; if (obs_addr !== 13'd0) begin bad++; $display("FAIL addr_above_top got=%0d exp=0", obs_addr); end
    endtask

    task automatic test_long_run();
        int px, py, ea;
        for (int f = 41; f <= 3600; f++) begin
            do_frame(1'b1);
            total++;
            if (obs_active !== model_active()) begin
                bad++;
                $display("FAIL run_active f=%0d got=%b exp=%b", f, obs_active, model_active());
            end
            for (int i = 0; i < 3; i++) begin
                if (m_act[i]) begin
                    px = m_x[i] + (i * 17 + 5) % 49;
                    py = 258 + i * 23;
                    x  = px[9:0];
                    y  = py[8:0];
                    #1;
                    ea = model_addr(px, py);
                    total++;
                    if (obs_addr !== 13'(ea)) begin
                        bad++;
                        $display("FAIL run_addr f=%0d x=%0d y=%0d got=%0d exp=%0d", f, px, py, obs_addr, ea);
                    end
                end
            end
            if (f == 600) begin
                total++; if (speed !== 3'd2) begin bad++; $display("FAIL speed_f600 got=%0d exp=2", speed); end
                total++; if (score !== 16'd100) begin bad++; $display("FAIL score_f600 got=%0d exp=100", score); end
            end
            if (f % 100 == 0) begin
                total++;
                if (speed !== 3'(model_speed()) || score !== 16'(model_score())) begin
                    bad++;
                    $display("FAIL run_progress f=%0d speed=%0d score=%0d exp_speed=%0d exp_score=%0d",
                             f, speed, score, model_speed(), model_score());
                end
            end
        end
        total++; if (score !== 16'd600) begin bad++; $display("FAIL score_f3600 got=%0d exp=600", score); end
        total++; if (speed !== 3'd6) begin bad++; $display("FAIL speed_f3600 got=%0d exp=6", speed); end
    endtask

    task automatic test_collision();
        int guard;
        int slot;
        int exp_score;
        int px, py;
        guard = 0;
        while (guard < 300) begin
            if ((m_act[0] || m_act[1] || m_act[2]) && (m_run_frames % 6) == 5) break;
            do_frame(1'b1);
            total++;
            if (obs_active !== model_active()) begin
                bad++;
                $display("FAIL pre_coll_active got=%b exp=%b", obs_active, model_active());
            end
            guard++;
        end
        if (guard >= 300) begin
            total++; bad++;
            $display("FAIL coll_setup_timeout got=%0d exp<300", guard);
        end
        slot = 0;
        for (int i = 2; i >= 0; i--) if (m_act[i]) slot = i;
        px = m_x[slot] + 10;
        py = 265;
        exp_score = model_score();

        @(negedge clk);
        x = px[9:0]; y = py[8:0];
        pix_valid = 1'b0; obs_sprite_bit = 1'b1; dino_opaque = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (obs_pix !== 1'b1) begin bad++; $display("FAIL box_obs_pix got=%b exp=1", obs_pix); end
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL no_coll_without_valid got=%0d exp=1", game_state); end

        pix_valid = 1'b1;
        @(negedge clk);
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL coll_not_yet got=%0d exp=1", game_state); end
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick(1'b0);
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL coll_game_over got=%b exp=1", game_over); end
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL coll_state got=%0d exp=2", game_state); end
        total++; if (score !== 16'(exp_score)) begin bad++; $display("FAIL coll_frame_score got=%0d exp=%0d", score, exp_score); end

        pix_valid = 1'b0; obs_sprite_bit = 1'b0; dino_opaque = 1'b0;
        repeat (3) do_frame(1'b0);
        total++; if (score !== 16'(exp_score)) begin bad++; $display("FAIL over_score_frozen got=%0d exp=%0d", score, exp_score); end
        total++; if (obs_active !== model_active()) begin bad++; $display("FAIL over_active_frozen got=%b exp=%b", obs_active, model_active()); end
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL over_start_held got=%0d exp=2", game_state); end
    endtask

    task automatic test_restart();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if (game_state !== 2'd2) begin bad++; $display("FAIL over_start_low got=%0d exp=2", game_state); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL over_to_idle got=%0d exp=0", game_state); end
        @(negedge clk);
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL idle_holds got=%0d exp=0", game_state); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear_run();
        total++; if (game_state !== 2'd1) begin bad++; $display("FAIL restart_state got=%0d exp=1", game_state); end
        total++; if (score !== 16'd0) begin bad++; $display("FAIL restart_score got=%0d exp=0", score); end
        total++; if (speed !== 3'd1) begin bad++; $display("FAIL restart_speed got=%0d exp=1", speed); end
        total++; if (obs_active !== 3'b000) begin bad++; $display("FAIL restart_active got=%b exp=000", obs_active); end
    endtask

    task automatic test_async_reset();
        for (int f = 1; f <= 45; f++) do_frame(1'b1);
        total++; if (score !== 16'd7) begin bad++; $display("FAIL midrun_score got=%0d exp=7", score); end
        total++; if (obs_active !== 3'b001) begin bad++; $display("FAIL midrun_active got=%b exp=001", obs_active); end
        x = 10'd560; y = 9'd260; obs_sprite_bit = 1'b1;
        @(negedge clk);
        total++; if (obs_pix !== 1'b1) begin bad++; $display("FAIL midrun_obs_pix got=%b exp=1", obs_pix); end
        #2 reset = 1'b1;
        #1;
        total++; if (game_state !== 2'd0) begin bad++; $display("FAIL async_state got=%0d exp=0", game_state); end
        total++; if (score !== 16'd0) begin bad++; $display("FAIL async_score got=%0d exp=0", score); end
        total++; if (speed !== 3'd1) begin bad++; $display("FAIL async_speed got=%0d exp=1", speed); end
        total++; if (obs_active !== 3'b000) begin bad++; $display("FAIL async_active got=%b exp=000", obs_active); end
        total++; if (obs_pix !== 1'b0) begin bad++; $display("FAIL async_obs_pix got=%b exp=0", obs_pix); end
        total++; if (obs_addr !== 13'd0) begin bad++; $display("FAIL async_obs_addr got=%0d exp=0", obs_addr); end
        @(negedge clk);
        reset = 1'b0;
        obs_sprite_bit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_long_run();
        test_collision();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
